// File: rtl/bp_pkg.sv
// bp_pkg: shared types and constants for branch resolution and predictor update
package bp_pkg;

    localparam int          UPD_ENTRY_W = 33;
    localparam logic [31:0] PC_INC      = 32'd4;

    typedef enum logic {
        IDLE,
        FLUSH
    } rd_state_t;

endpackage

// File: rtl/upd_fifo.sv
// upd_fifo: synchronous FIFO with registered count and full/empty flags
module upd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_d;
    logic          do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    // Head is forced to zero while empty so the predictor port idles at a known value
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (do_push & ~do_pop) count_d = count + (AW+1)'(1);
        if (do_pop & ~do_push) count_d = count - (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_d;
            full  <= count_d == (AW+1)'(DEPTH);
            empty <= count_d == '0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/br_resolve.sv
// br_resolve: EX-stage branch resolution, one-cycle redirect and in-order predictor update queue
module br_resolve
    import bp_pkg::*;
#(
    parameter int UQ_DEPTH = 4,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_is_cond,
    input  logic             ex_is_jump,
    input  logic [31:0]      ex_pc,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic             ex_stall,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    input  logic             upd_ready,
    output logic             upd_we,
    output logic             upd_branched,
    output logic [31:0]      upd_pc,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mis_cnt
);
    rd_state_t              state_q, state_d;
    logic                   squash_q, resolve, mispred, push, full, empty;
    logic [31:0]            next_pc;
    logic [UPD_ENTRY_W-1:0] head;

    assign squash_q = state_q == FLUSH;
    assign resolve  = ex_valid & ~ex_stall & ~squash_q;
    assign mispred  = resolve & (ex_is_cond | ex_is_jump) &
                      ((ex_pred_taken != ex_taken) | (ex_taken & (ex_pred_target != ex_target)));
    assign next_pc  = ex_taken ? ex_target : ex_pc + PC_INC;
    assign push     = resolve & ex_is_cond;
    assign ex_stall = full;
    assign upd_we   = ~empty & upd_ready;
    assign upd_pc       = head[UPD_ENTRY_W-1:1];
    assign upd_branched = head[0];
    assign flush          = squash_q;
    assign redirect_valid = squash_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mispred) state_d = FLUSH;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            redirect_pc <= '0;
            br_cnt      <= '0;
            mis_cnt     <= '0;
        end else begin
            state_q <= state_d;
            if (mispred) redirect_pc <= next_pc;
            if (push && br_cnt != '1) br_cnt <= br_cnt + CNT_W'(1);
            if (mispred && mis_cnt != '1) mis_cnt <= mis_cnt + CNT_W'(1);
        end
    end

    upd_fifo #(
        .DEPTH (UQ_DEPTH),
        .W     (UPD_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({ex_pc, ex_taken}),
        .pop   (upd_we),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_br_resolve.sv
// tb_br_resolve: directed self-checking bench for br_resolve
module tb_br_resolve;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0, ex_is_cond = 1'b0, ex_is_jump = 1'b0;
    logic [31:0] ex_pc = '0, ex_pred_target = '0, ex_target = '0;
    logic        ex_pred_taken = 1'b0, ex_taken = 1'b0;
    logic        ex_stall, flush, redirect_valid;
    logic [31:0] redirect_pc, upd_pc;
    logic        upd_ready = 1'b1;
    logic        upd_we, upd_branched;
    logic [31:0] br_cnt, mis_cnt;
    int          checks = 0;
    int          failures = 0;

    br_resolve #(.UQ_DEPTH(4), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_is_cond     (ex_is_cond),
        .ex_is_jump     (ex_is_jump),
        .ex_pc          (ex_pc),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_stall       (ex_stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .upd_ready      (upd_ready),
        .upd_we         (upd_we),
        .upd_branched   (upd_branched),
        .upd_pc         (upd_pc),
        .br_cnt         (br_cnt),
        .mis_cnt        (mis_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ex_valid = 1'b0; ex_is_cond = 1'b0; ex_is_jump = 1'b0;
        #1;
    endtask

    task automatic drive(input logic cond, input logic jump, input logic [31:0] pc,
                         input logic pt, input logic [31:0] ptt, input logic t, input logic [31:0] tt);
        ex_valid = 1'b1; ex_is_cond = cond; ex_is_jump = jump; ex_pc = pc;
        ex_pred_taken = pt; ex_pred_target = ptt; ex_taken = t; ex_target = tt;
        #1;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_flush"}, 32'(flush), 32'd0);
        chk({pfx, "_rv"}, 32'(redirect_valid), 32'd0);
        chk({pfx, "_rpc"}, redirect_pc, 32'd0);
        chk({pfx, "_we"}, 32'(upd_we), 32'd0);
        chk({pfx, "_upc"}, upd_pc, 32'd0);
        chk({pfx, "_ubr"}, 32'(upd_branched), 32'd0);
        chk({pfx, "_stall"}, 32'(ex_stall), 32'd0);
        chk({pfx, "_br"}, br_cnt, 32'd0);
        chk({pfx, "_mis"}, mis_cnt, 32'd0);
    endtask

    task automatic scen1(input string pfx);
        drive(1, 0, 32'h1C00_0100, 0, 32'h1C00_0500, 0, 32'h1C00_0500);
        tick();
        idle_in();
        chk({pfx, "_flush"}, 32'(flush), 32'd0);
        chk({pfx, "_we"}, 32'(upd_we), 32'd1);
        chk({pfx, "_upc"}, upd_pc, 32'h1C00_0100);
        chk({pfx, "_ubr"}, 32'(upd_branched), 32'd0);
        chk({pfx, "_br"}, br_cnt, 32'd1);
        chk({pfx, "_mis"}, mis_cnt, 32'd0);
        tick();
        chk({pfx, "_drain"}, 32'(upd_we), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        chk_reset_vals("rst0");
        rst = 1'b0;
        tick();

        scen1("s1");

        // not-taken prediction, taken outcome; the next EX instruction is wrong-path
        drive(1, 0, 32'h1C00_0180, 0, 32'h0, 1, 32'h1C00_0200);
        tick();
        drive(1, 0, 32'h1C00_01A0, 0, 32'h0, 0, 32'h0);
        chk("s2_flush", 32'(flush), 32'd1);
        chk("s2_rv", 32'(redirect_valid), 32'd1);
        chk("s2_rpc", redirect_pc, 32'h1C00_0200);
        chk("s2_mis", mis_cnt, 32'd1);
        chk("s2_br", br_cnt, 32'd2);
        chk("s2_upc", upd_pc, 32'h1C00_0180);
        chk("s2_ubr", 32'(upd_branched), 32'd1);
        tick();
        idle_in();
        chk("s2_flush_off", 32'(flush), 32'd0);
        chk("s2_squash_noenq", 32'(upd_we), 32'd0);
        chk("s2_squash_br", br_cnt, 32'd2);

        // taken with wrong target
        drive(1, 0, 32'h1C00_0280, 1, 32'h1C00_0300, 1, 32'h1C00_0340);
        tick();
        idle_in();
        chk("s3_flush", 32'(flush), 32'd1);
        chk("s3_rpc", redirect_pc, 32'h1C00_0340);
        chk("s3_ubr", 32'(upd_branched), 32'd1);
        chk("s3_upc", upd_pc, 32'h1C00_0280);
        chk("s3_mis", mis_cnt, 32'd2);
        chk("s3_br", br_cnt, 32'd3);
        tick();

        // back-pressure: fill the queue with upd_ready low
        upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 32'h1000_0000 + 32'(i * 4), i[0], 32'h2000_0000, i[0], 32'h2000_0000);
            chk($sformatf("s4_nostall%0d", i), 32'(ex_stall), 32'd0);
            tick();
        end
        drive(1, 0, 32'h1000_0010, 0, 32'h2000_0000, 0, 32'h2000_0000);
        chk("s4_stall", 32'(ex_stall), 32'd1);
        chk("s4_we_held", 32'(upd_we), 32'd0);
        tick();
        tick();
        chk("s4_stall_hold", 32'(ex_stall), 32'd1);
        chk("s4_br_hold", br_cnt, 32'd7);
        chk("s4_flush_none", 32'(flush), 32'd0);
        upd_ready = 1'b1;
        #1;
        chk("s4_we0", 32'(upd_we), 32'd1);
        chk("s4_upc0", upd_pc, 32'h1000_0000);
        chk("s4_ubr0", 32'(upd_branched), 32'd0);
        tick();
        chk("s4_unstall", 32'(ex_stall), 32'd0);
        chk("s4_upc1", upd_pc, 32'h1000_0004);
        chk("s4_ubr1", 32'(upd_branched), 32'd1);
        tick();
        idle_in();
        for (int i = 2; i < 5; i++) begin
            chk($sformatf("s4_we%0d", i), 32'(upd_we), 32'd1);
            chk($sformatf("s4_upc%0d", i), upd_pc, 32'h1000_0000 + 32'(i * 4));
            chk($sformatf("s4_ubr%0d", i), 32'(upd_branched), 32'(i % 2 == 1 && i < 4));
            tick();
        end
        chk("s4_empty", 32'(upd_we), 32'd0);
        chk("s4_br", br_cnt, 32'd8);

        // jump at top of address space, recomputed not-taken
        drive(0, 1, 32'hFFFF_FFFC, 1, 32'h0000_0100, 0, 32'h0000_0100);
        tick();
        idle_in();
        chk("s5_flush", 32'(flush), 32'd1);
        chk("s5_rpc_wrap", redirect_pc, 32'h0000_0000);
        chk("s5_noenq", 32'(upd_we), 32'd0);
        chk("s5_br", br_cnt, 32'd8);
        chk("s5_mis", mis_cnt, 32'd3);
        tick();

        // mid-cycle async reset with 3 queued entries and FLUSH active
        upd_ready = 1'b0;
        drive(1, 0, 32'h3000_0000, 0, 32'h0, 0, 32'h0);
        tick();
        drive(1, 0, 32'h3000_0004, 0, 32'h0, 0, 32'h0);
        tick();
        drive(1, 0, 32'h3000_0008, 0, 32'h0, 1, 32'h3000_0100);
        tick();
        idle_in();
        chk("s6_pre_flush", 32'(flush), 32'd1);
        chk("s6_pre_upc", upd_pc, 32'h3000_0000);
        #2;
        rst = 1'b1;
        upd_ready = 1'b1;
        #1;
        chk_reset_vals("s6_rst");
        tick();
        rst = 1'b0;
        tick();
        scen1("s6_post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/br_resolve.md
# br_resolve

EX-stage branch resolution and predictor-update unit. Compares each resolved branch against the prediction carried down from IF1. On a mismatch it issues a one-cycle flush/redirect. It also queues every conditional-branch outcome, in program order, into the IF1 global-history predictor's write port (`we`/`branched`/`ex_pc`). The queue is needed because the predictor accepts at most one update per cycle and may refuse an update when its table port is busy with an IF1 lookup.

## Interface
- `UQ_DEPTH`, 4, update-queue entries (power of two, ≥2)
- `CNT_W`, 32, width of performance counters
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `ex_valid`  in  1  EX holds a valid instruction this cycle
- `ex_is_cond`  in  1  instruction is a conditional branch
- `ex_is_jump`  in  1  instruction is an unconditional jump/jump-register
- `ex_pc`  in  32  instruction PC
- `ex_pred_taken`  in  1  direction predicted in IF1
- `ex_pred_target`  in  32  target predicted in IF1
- `ex_taken`  in  1  actual direction (forced 1 for jumps)
- `ex_target`  in  32  actual target
- `ex_stall`  out  1  EX must hold its instruction; queue full
- `flush`  out  1  squash IF1..EX younger instructions
- `redirect_valid`  out  1  fetch must restart at `redirect_pc`
- `redirect_pc`  out  32  correct next PC
- `upd_ready`  in  1  predictor can accept an update this cycle
- `upd_we`  out  1  predictor update strobe (drives predictor `we`)
- `upd_branched`  out  1  outcome (drives predictor `branched`)
- `upd_pc`  out  32  branch PC (drives predictor `ex_pc`)
- `br_cnt`, `mis_cnt`  out  CNT_W  resolved-branch and mispredict counters

## Operation
- An EX instruction is consumed when `ex_valid & ~ex_stall & ~squash_q`. A consumed instruction is a "resolve".
- Mispredict is `(ex_pred_taken != ex_taken) | (ex_taken & (ex_pred_target != ex_target))`. It is evaluated only for resolves with `ex_is_cond | ex_is_jump`.
- Correct next PC is `ex_taken ? ex_target : ex_pc + 32'd4`. The add wraps modulo 2^32.
- Redirect state machine:
  - IDLE: a mispredicting resolve registers `redirect_pc` and moves to FLUSH.
  - FLUSH: lasts one cycle. `flush = redirect_valid = 1` and `squash_q = 1`. EX inputs are ignored because they are wrong-path. Returns to IDLE.
- Update queue: a FIFO of `{pc, taken}`.
  - Enqueue: every resolve with `ex_is_cond`, including mispredicting ones. Jumps are never enqueued.
  - Dequeue: when `upd_we`, with `upd_we = ~empty & upd_ready`.
  - `upd_branched` and `upd_pc` come from the head entry and are stable while `~empty`.
  - Program order is strict, because the predictor history shifts once per `we`.
- `ex_stall = full`, purely from the count register. While stalled, nothing is enqueued and no redirect is evaluated. EX must hold its inputs.
- Simultaneous enqueue and dequeue when not full: the count is unchanged and both take effect.
- Counters:
  - `br_cnt` increments on each conditional resolve.
  - `mis_cnt` increments on each mispredicting resolve, whether branch or jump.
  - Both saturate at all-ones.

## Timing
- Reset values: `flush = redirect_valid = 0`, `redirect_pc = 0`, queue empty (`upd_we = 0`, `upd_branched = 0`, `upd_pc = 0`), `ex_stall = 0`, counters 0, state IDLE.
- Reset asserted mid-operation clears the queue; pending updates are lost. This is legal because the predictor resets with the same `rst`.
- A resolve in cycle N produces:
  - `flush` and `redirect_valid` in cycle N+1, for exactly one cycle.
  - earliest `upd_we` in cycle N+1 for that entry.
- Back-to-back mispredicts are impossible: the instruction in N+1 is squashed. The next redirect is therefore N+2 at the earliest.
- `ex_stall` rises in the cycle after the enqueue that fills the queue. It falls in the cycle after the first dequeue from full.
- `upd_ready = 0` indefinitely causes the queue to fill, then stall. This must not cause deadlock, redirect loss or reordering.

## Structure
- Shared package `bp_pkg`: `UPD_ENTRY_W = 33`, the redirect state encoding (IDLE, FLUSH), and the PC increment constant `4`.
- One sub-module, `upd_fifo`: a parameterised synchronous FIFO with registered count and full/empty flags.
- Top-level logic: mispredict compare, redirect FSM, counters.

## Test plan
- Correctly predicted not-taken branch at PC `0x1C000100`:
  - no flush;
  - N+1: `upd_we = 1`, `upd_pc = 0x1C000100`, `upd_branched = 0`;
  - `br_cnt = 1`, `mis_cnt = 0`.
- Predicted not-taken, actually taken to `0x1C000200`:
  - N+1: `flush = 1`, `redirect_pc = 0x1C000200`;
  - the EX instruction presented in N+1 is not enqueued;
  - `mis_cnt = 1`.
- Taken branch with predicted target `0x...300` but actual target `0x...340`:
  - redirect to `0x...340`;
  - update `branched = 1`.
- Hold `upd_ready = 0` and issue 5 conditional branches:
  - `ex_stall = 1` after the 4th;
  - release `upd_ready`: 5 updates emerge in issue order, one per cycle.
- Jump mispredict at `0xFFFFFFFC` with not-taken recomputation:
  - checks `pc + 4` wraps to `0x00000000`;
  - no update is enqueued for the jump.
- Assert `rst` asynchronously mid-cycle while the queue holds 3 entries and FLUSH is active:
  - all outputs drop to their reset values immediately;
  - first post-reset branch behaves as in scenario 1.
